// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment capture path.
// Segment bit order is {g,f,e,d,c,b,a}, active-high.
package seg7_pkg;

    localparam logic [6:0] SEG_BLANK   = 7'b0000000;
    localparam logic [6:0] SEG_DIGIT_0 = 7'b0111111;
    localparam logic [6:0] SEG_DIGIT_1 = 7'b0000110;
    localparam logic [6:0] SEG_DIGIT_2 = 7'b1011011;
    localparam logic [6:0] SEG_DIGIT_3 = 7'b1001111;
    localparam logic [6:0] SEG_DIGIT_4 = 7'b1100110;
    localparam logic [6:0] SEG_DIGIT_5 = 7'b1101101;
    localparam logic [6:0] SEG_DIGIT_6 = 7'b1111101;
    localparam logic [6:0] SEG_DIGIT_7 = 7'b0000111;
    localparam logic [6:0] SEG_DIGIT_8 = 7'b1111111;
    localparam logic [6:0] SEG_DIGIT_9 = 7'b1101111;

    localparam logic [3:0] BCD_BLANK   = 4'hF;

    // Decoder result bundled for the commit logic.
    typedef struct packed {
        logic [3:0] value;
        logic       is_digit;
        logic       is_blank;
    } seg7_dec_t;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational 7-segment pattern to BCD decoder.
// Unknown patterns report neither digit nor blank and return BCD_BLANK.
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  logic [6:0] pattern,
    output logic [3:0] value,
    output logic       is_digit,
    output logic       is_blank
);

    // Table lookup; blank and illegal codes both return BCD_BLANK.
    always_comb begin
        value    = BCD_BLANK;
        is_digit = 1'b1;
        is_blank = 1'b0;
        case (pattern)
            SEG_DIGIT_0: value = 4'd0;
            SEG_DIGIT_1: value = 4'd1;
            SEG_DIGIT_2: value = 4'd2;
            SEG_DIGIT_3: value = 4'd3;
            SEG_DIGIT_4: value = 4'd4;
            SEG_DIGIT_5: value = 4'd5;
            SEG_DIGIT_6: value = 4'd6;
            SEG_DIGIT_7: value = 4'd7;
            SEG_DIGIT_8: value = 4'd8;
            SEG_DIGIT_9: value = 4'd9;
            SEG_BLANK: begin
                is_digit = 1'b0;
                is_blank = 1'b1;
            end
            default: is_digit = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg7_bcd_capture.sv
// Reconstructs per-digit BCD values from a scanned 7-segment bus.
// Each (pattern, select) window must be stable for STABLE_CYCLES
// registered samples before it is committed, exactly once per window.
// Build option: SEG7_ACTIVE_LOW_EN inverts Segments/DigitSel at the
// input register for common-anode displays.
module seg7_bcd_capture
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [6:0]              Segments,
    input  logic [NUM_DIGITS-1:0]   DigitSel,
    output logic [4*NUM_DIGITS-1:0] BCD,
    output logic [NUM_DIGITS-1:0]   DigitValid,
    output logic                    Update,
    output logic                    PatErr,
    output logic                    SelErr
);

    localparam int             CW      = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0]  CNT_MAX = CW'(STABLE_CYCLES);

    logic [6:0]            seg_d, seg_q;
    logic [NUM_DIGITS-1:0] sel_d, sel_q;

`ifdef SEG7_ACTIVE_LOW_EN
    assign seg_d = ~Segments;
    assign sel_d = ~DigitSel;
`else
    assign seg_d = Segments;
    assign sel_d = DigitSel;
`endif

    // Input register stage; holds the logical (active-high) sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            seg_q <= '0;
            sel_q <= '0;
        end else begin
            seg_q <= seg_d;
            sel_q <= sel_d;
        end
    end

    logic                  sel_onehot, sel_multi, same;
    logic [6:0]            cand_pat;
    logic [NUM_DIGITS-1:0] cand_sel;
    logic [CW-1:0]         stab_cnt, cnt_nxt;
    logic                  committed, commit;

    assign sel_onehot = ($countones(sel_q) == 1);
    assign sel_multi  = ($countones(sel_q) > 1);
    assign same       = (seg_q == cand_pat) && (sel_q == cand_sel);

    // Next stability count; commit fires on the edge the count reaches max.
    always_comb begin
        cnt_nxt = '0;
        if (sel_onehot) begin
            if (!same)                    cnt_nxt = CW'(1);
            else if (stab_cnt == CNT_MAX) cnt_nxt = stab_cnt;
            else                          cnt_nxt = stab_cnt + CW'(1);
        end
    end

    assign commit = sel_onehot && (cnt_nxt == CNT_MAX) && !committed;

    // Stability tracker: candidate, run counter and once-per-window flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            cand_pat  <= '0;
            cand_sel  <= '0;
            stab_cnt  <= '0;
            committed <= 1'b0;
        end else begin
            stab_cnt <= cnt_nxt;
            if (sel_onehot) begin
                if (!same) begin
                    cand_pat  <= seg_q;
                    cand_sel  <= sel_q;
                    committed <= 1'b0;
                end else begin
                    committed <= committed | commit;
                end
            end else begin
                committed <= 1'b0;
            end
        end
    end

    // On a commit the sample equals the candidate, so decode the sample.
    seg7_dec_t dec;

    seg7_pattern_decode u_dec (
        .pattern  (seg_q),
        .value    (dec.value),
        .is_digit (dec.is_digit),
        .is_blank (dec.is_blank)
    );

    logic legal;
    assign legal = dec.is_digit | dec.is_blank;

    // Registered single-cycle status pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            Update <= 1'b0;
            PatErr <= 1'b0;
            SelErr <= 1'b0;
        end else begin
            Update <= commit & legal;
            PatErr <= commit & ~legal;
            SelErr <= sel_multi;
        end
    end

    logic [NUM_DIGITS-1:0][3:0] bcd_r;

    // Per-digit result registers; only the selected digit is touched.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_DIGITS; i++) bcd_r[i] <= BCD_BLANK;
            DigitValid <= '0;
        end else if (commit && legal) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (sel_q[i]) begin
                    bcd_r[i]      <= dec.value;
                    DigitValid[i] <= dec.is_digit;
                end
            end
        end
    end

    assign BCD = bcd_r;

endmodule

// File: tb/tb_seg7_bcd_capture.sv
// Self-checking bench for seg7_bcd_capture (NUM_DIGITS=4, STABLE_CYCLES=4).
// A run-length reference model is checked every cycle; directed sequences
// and a vector table add explicit expectations.
module tb_seg7_bcd_capture;

    localparam int ND = 4;
    localparam int N  = 4;
    localparam logic [6:0] PT [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                       7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [6:0]    Segments;
    logic [ND-1:0] DigitSel;
    logic [4*ND-1:0] BCD;
    logic [ND-1:0] DigitValid;
    logic          Update, PatErr, SelErr;

    seg7_bcd_capture #(.NUM_DIGITS(ND), .STABLE_CYCLES(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .Segments   (Segments),
        .DigitSel   (DigitSel),
        .BCD        (BCD),
        .DigitValid (DigitValid),
        .Update     (Update),
        .PatErr     (PatErr),
        .SelErr     (SelErr)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Logical (active-high) view of what is on the pins.
    logic [6:0]    cur_seg;
    logic [ND-1:0] cur_sel;

    // Reference model state.
    logic [6:0]    m_rseg, m_lseg;
    logic [ND-1:0] m_rsel, m_lsel;
    int            m_run;
    logic [3:0]    m_bcd [ND];
    logic [ND-1:0] m_val;
    logic          m_upd, m_pat, m_selerr;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [6:0] s, input logic [ND-1:0] d);
        cur_seg = s;
        cur_sel = d;
`ifdef SEG7_ACTIVE_LOW_EN
        Segments = ~s;
        DigitSel = ~d;
`else
        Segments = s;
        DigitSel = d;
`endif
    endtask

    // Model of one rising edge: tracker acts on the previously registered
    // sample, then the current pins become the registered sample.
    task automatic model_edge();
        int pc, idx, val;
        if (rst) begin
            m_rseg = '0; m_rsel = '0; m_lseg = '0; m_lsel = '0; m_run = 0;
            for (int i = 0; i < ND; i++) m_bcd[i] = 4'hF;
            m_val = '0; m_upd = 0; m_pat = 0; m_selerr = 0;
            return;
        end
        m_upd = 0; m_pat = 0; m_selerr = 0;
        pc = $countones(m_rsel);
        if (pc == 1) begin
            if (m_run > 0 && m_rseg == m_lseg && m_rsel == m_lsel) m_run++;
            else begin
                m_run = 1; m_lseg = m_rseg; m_lsel = m_rsel;
            end
            if (m_run == N) begin
                idx = 0;
                for (int i = 0; i < ND; i++) if (m_rsel[i]) idx = i;
                val = -1;
                for (int k = 0; k < 10; k++) if (PT[k] == m_rseg) val = k;
                if (val >= 0) begin
                    m_bcd[idx] = 4'(val); m_val[idx] = 1'b1; m_upd = 1;
                end else if (m_rseg == 7'b0) begin
                    m_bcd[idx] = 4'hF; m_val[idx] = 1'b0; m_upd = 1;
                end else m_pat = 1;
            end
        end else begin
            m_run = 0;
            m_selerr = (pc > 1);
        end
        m_rseg = cur_seg;
        m_rsel = cur_sel;
    endtask

    task automatic check_model();
        logic [4*ND-1:0] eb;
        for (int i = 0; i < ND; i++) eb[4*i +: 4] = m_bcd[i];
        chk("model_bcd", 32'(BCD), 32'(eb));
        chk("model_valid", 32'(DigitValid), 32'(m_val));
        chk("model_update", 32'(Update), 32'(m_upd));
        chk("model_paterr", 32'(PatErr), 32'(m_pat));
        chk("model_selerr", 32'(SelErr), 32'(m_selerr));
    endtask

    // One clock: edge, model update, sample 1 time unit later.
    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
        check_model();
    endtask

    typedef struct packed {
        logic [6:0] seg;
        logic [1:0] pos;
        logic [3:0] nib;
        logic       vld;
        logic       upd;
        logic       perr;
    } vec_t;

    vec_t vt [12];

    initial begin
        logic [6:0] rs;
        logic [3:0] rd;
        int hold;

        vt[0]  = '{PT[0],   2'd0, 4'h0, 1'b1, 1'b1, 1'b0};
        vt[1]  = '{PT[7],   2'd1, 4'h7, 1'b1, 1'b1, 1'b0};
        vt[2]  = '{PT[8],   2'd2, 4'h8, 1'b1, 1'b1, 1'b0};
        vt[3]  = '{PT[9],   2'd3, 4'h9, 1'b1, 1'b1, 1'b0};
        vt[4]  = '{PT[6],   2'd0, 4'h6, 1'b1, 1'b1, 1'b0};
        vt[5]  = '{7'h70,   2'd0, 4'h6, 1'b1, 1'b0, 1'b1};
        vt[6]  = '{7'h00,   2'd1, 4'hF, 1'b0, 1'b1, 1'b0};
        vt[7]  = '{PT[4],   2'd1, 4'h4, 1'b1, 1'b1, 1'b0};
        vt[8]  = '{7'h01,   2'd2, 4'h8, 1'b1, 1'b0, 1'b1};
        vt[9]  = '{PT[1],   2'd3, 4'h1, 1'b1, 1'b1, 1'b0};
        vt[10] = '{PT[2],   2'd2, 4'h2, 1'b1, 1'b1, 1'b0};
        vt[11] = '{PT[5],   2'd3, 4'h5, 1'b1, 1'b1, 1'b0};

        // Reset
        rst = 1'b1;
        drive(7'h00, 4'b0000);
        cyc(); cyc();
        chk("reset_bcd", 32'(BCD), 32'hFFFF);
        chk("reset_valid", 32'(DigitValid), 0);
        chk("reset_pulses", {29'd0, Update, PatErr, SelErr}, 0);
        rst = 1'b0;
        cyc();

        // Commit on digit 1 after four held edges, exactly one Update
        drive(PT[3], 4'b0010);
        for (int i = 1; i <= 4; i++) begin
            cyc();
            chk("commit_no_early_update", 32'(Update), 0);
        end
        cyc();
        chk("commit_bcd", 32'(BCD[7:4]), 3);
        chk("commit_valid", 32'(DigitValid), 32'b0010);
        chk("commit_update", 32'(Update), 1);
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("commit_single_update", 32'(Update), 0);
        end

        // Glitch restart on digit 2
        drive(PT[3], 4'b0100);
        cyc(); cyc();
        drive(PT[2], 4'b0100);
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("glitch_no_update", 32'(Update), 0);
        end
        cyc();
        chk("glitch_update", 32'(Update), 1);
        chk("glitch_bcd", 32'(BCD[11:4]), 32'h23);
        chk("glitch_valid", 32'(DigitValid), 32'b0110);

        // Digit 0: value 5, illegal pattern leaves it, then blank
        drive(PT[5], 4'b0001);
        repeat (5) cyc();
        chk("d0_five", 32'(BCD[3:0]), 5);
        drive(7'b1000000, 4'b0001);
        repeat (4) cyc();
        cyc();
        chk("illegal_paterr", 32'(PatErr), 1);
        chk("illegal_no_update", 32'(Update), 0);
        chk("illegal_keeps", 32'(BCD[3:0]), 5);
        chk("illegal_valid", 32'(DigitValid[0]), 1);
        cyc();
        chk("illegal_pulse_once", 32'(PatErr), 0);
        drive(7'b0000000, 4'b0001);
        repeat (4) cyc();
        cyc();
        chk("blank_update", 32'(Update), 1);
        chk("blank_bcd", 32'(BCD[3:0]), 32'hF);
        chk("blank_valid", 32'(DigitValid[0]), 0);

        // Multi-hot select, then idle select
        drive(PT[1], 4'b0110);
        cyc();
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("selerr_pulse", 32'(SelErr), 1);
            chk("selerr_no_update", 32'(Update), 0);
        end
        drive(PT[1], 4'b0000);
        cyc();
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("idle_quiet", {30'd0, SelErr, Update}, 0);
        end

        // Full scan 1,2,3,4
        for (int d = 0; d < ND; d++) begin
            drive(PT[d+1], ND'(1 << d));
            repeat (5) cyc();
        end
        chk("scan_bcd", 32'(BCD), 32'h4321);
        chk("scan_valid", 32'(DigitValid), 32'hF);

        // Vector table
        for (int v = 0; v < 12; v++) begin
            drive(vt[v].seg, ND'(1 << vt[v].pos));
            repeat (4) cyc();
            cyc();
            chk($sformatf("vec%0d_nib", v), 32'(BCD[4*vt[v].pos +: 4]), 32'(vt[v].nib));
            chk($sformatf("vec%0d_vld", v), 32'(DigitValid[vt[v].pos]), 32'(vt[v].vld));
            chk($sformatf("vec%0d_upd", v), 32'(Update), 32'(vt[v].upd));
            chk($sformatf("vec%0d_perr", v), 32'(PatErr), 32'(vt[v].perr));
        end

        // Randomized phase against the model
        for (int it = 0; it < 400; it++) begin
            int r, k;
            r = $urandom_range(0, 11);
            if (r < 10) rs = PT[r];
            else if (r == 10) rs = 7'h00;
            else begin
                rd = 4'($urandom);
                rs = 7'($urandom);
            end
            k = $urandom_range(0, 7);
            if (k == 0) rd = 4'b0000;
            else if (k == 1) rd = 4'b1010 | 4'($urandom_range(0, 15));
            else rd = ND'(1 << $urandom_range(0, ND - 1));
            rst = ($urandom_range(0, 49) == 0);
            drive(rs, rd);
            hold = $urandom_range(1, 7);
            for (int h = 0; h < hold; h++) begin
                cyc();
                rst = 1'b0;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg7_bcd_capture.md
Name: seg7_bcd_capture

Overview:
- Receive side of the BCD-to-7-segment path. Watches a multiplexed, one-hot-scanned 7-segment display bus and reconstructs the BCD digit driven on each position.
- Filters each digit slot for stability before committing, then publishes per-digit BCD, valid flags and an update pulse.
- Used for display loopback self-check and for capturing external segment-driven displays.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digit positions (1..8).
- STABLE_CYCLES, 4, consecutive identical samples required before commit (2..255).

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- Segments  input  7  segment lines. Bit0=a … bit6=g, active-high.
- DigitSel  input  NUM_DIGITS  digit enables, expected one-hot, active-high.
- BCD  output  4*NUM_DIGITS  captured digits; digit i occupies bits [4i+3:4i].
- DigitValid  output  NUM_DIGITS  digit i holds a committed decimal value.
- Update  output  1  one-cycle pulse when any digit is committed or blanked.
- PatErr  output  1  one-cycle pulse when a stable pattern is not a legal code.
- SelErr  output  1  one-cycle pulse when the sampled DigitSel is multi-hot.

Behaviour:
- Reset (rst=1 at an edge): BCD=all 4'hF, DigitValid=0, Update=0, PatErr=0, SelErr=0. Input registers are cleared, stab_cnt=0, committed=0. Reset mid-stability window discards the window.
- Input stage: Segments and DigitSel are registered every edge (1 cycle).
- Tracker state: cand_pat, cand_idx, stab_cnt, committed.
  - A registered sample that is one-hot and equals (cand_pat, cand_idx): stab_cnt increments and saturates at STABLE_CYCLES.
  - Otherwise: cand loads the new sample, stab_cnt=1, committed=0.
- Zero-hot DigitSel: no sampling; stab_cnt=0, committed=0, no error.
- Multi-hot DigitSel: same as zero-hot, plus SelErr pulses for every such registered sample.
- Commit happens when stab_cnt reaches STABLE_CYCLES and committed=0. committed is then set, so each window commits exactly once.
- Latency: pattern and select held across input edges E1..EN (N=STABLE_CYCLES). Commit occurs at edge E(N+1). Outputs are visible after E(N+1).
- Commit actions on digit cand_idx:
  - Legal digit 0–9: BCD slot = value, DigitValid=1, Update=1.
  - Blank (7'b0000000): BCD slot = 4'hF, DigitValid=0, Update=1.
  - Any other pattern: slot and valid unchanged, PatErr=1, Update=0.
- Pattern table (g..a):
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110
  - 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111
- Other digits are never disturbed by a commit.
- Pulses (Update, PatErr, SelErr) are registered and deassert the following cycle unless retriggered.
- Scan rollover: a select change restarts the window even if Segments is unchanged.

Optional Feature:
- SEG7_ACTIVE_LOW_EN
  - Defined: Segments and DigitSel are inverted at the input register (common-anode displays). Blank is then all-ones on the pins.
  - Undefined: active-high as specified above.
- All downstream behaviour is identical in both builds.

Decomposition:
- Package seg7_pkg: SEG_BLANK, the ten SEG_DIGIT_n constants, BCD_BLANK=4'hF.
- One sub-module: seg7_pattern_decode. Combinational, 7-bit pattern in; outputs 4-bit value, is_digit, is_blank.
- The top level holds the input registers, the tracker and the per-digit output registers.

Test Plan:
- Reset: rst=1 for 2 cycles → BCD=16'hFFFF, DigitValid=0, all pulses 0.
- Commit: DigitSel=4'b0010, Segments=7'b1001111 held 4 edges → at edge 5, BCD[7:4]=3, DigitValid=4'b0010, Update high exactly 1 cycle. Holding longer gives no further Update.
- Glitch restart: same stimulus, but Segments changes to 7'b1011011 on the 3rd edge then holds 4 edges → only digit 2 commits, at 4 edges after the change.
- Blank and illegal:
  - Digit 0 shows 5, then 7'b0000000 for 4 edges → BCD[3:0]=F, DigitValid[0]=0, Update pulses.
  - 7'b1000000 held → PatErr pulses, digit unchanged.
- Selection errors: DigitSel=4'b0110 for 6 edges → SelErr pulses each registered cycle, no commit. DigitSel=0 → no activity.
- Full scan: rotate DigitSel through all 4 digits showing 1,2,3,4, 5 cycles each, with SEG7_ACTIVE_LOW_EN both defined (inverted stimulus) and undefined → BCD=16'h4321, DigitValid=4'hF.
